tcdm_bank_ts_adapter: RTL

Per-bank adapter sitting directly downstream of the cluster TCDM interconnect's memory-side ports, one instance per TCDM bank, between the interconnect's bank port and the single-port SRAM macro. It grants requests and translates the byte address to a word index. It generates the registered read/write response one cycle after grant. It also implements the cluster test-and-set atomic: a read with the test-and-set address bit set returns the old word, then writes all-ones to it in the following cycle.

---
 rtl/tcdm_bank_ts_adapter_pkg.sv | 14 +
 rtl/tcdm_bank_ts_adapter.sv | 104 ++++++++++
 2 files changed

// File: rtl/tcdm_bank_ts_adapter_pkg.sv
// Shared HCI bank-adapter definitions: FSM state encoding and the test-and-set fill word.
// Also used by the ECC bank variant.
package tcdm_bank_ts_adapter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    TS_SET = 1'b1
  } hci_ts_state_e;

  // Wide enough for any bank width; adapters slice the low DATA_WIDTH bits.
  localparam int unsigned HCI_TS_FILL_W = 1024;
  localparam logic [HCI_TS_FILL_W-1:0] HCI_TS_FILL = '1;

endpackage

// File: rtl/tcdm_bank_ts_adapter.sv
// Per-bank TCDM adapter: passes requests to a single-port SRAM and returns a one-cycle response.
// A read with the TS address bit set also writes all-ones to the same word in the following cycle.
module tcdm_bank_ts_adapter
  import tcdm_bank_ts_adapter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned ADDR_MEM_WIDTH = 11,
  parameter int unsigned TS_BIT         = 20,
  parameter int unsigned IW             = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      tcdm_req_i,
  output logic                      tcdm_gnt_o,
  input  logic [ADDR_WIDTH-1:0]     tcdm_add_i,
  input  logic                      tcdm_wen_i,
  input  logic [DATA_WIDTH-1:0]     tcdm_data_i,
  input  logic [DATA_WIDTH/8-1:0]   tcdm_be_i,
  input  logic [IW-1:0]             tcdm_id_i,
  output logic                      tcdm_r_valid_o,
  output logic [DATA_WIDTH-1:0]     tcdm_r_data_o,
  output logic [IW-1:0]             tcdm_r_id_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDR_MEM_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  if (TS_BIT <= ADDR_MEM_WIDTH + 1) begin : g_bad_ts_bit
    $error("TS_BIT must lie above the SRAM word-index bits");
  end

  hci_ts_state_e             state_q;
  logic [ADDR_MEM_WIDTH-1:0] ts_idx_q;
  logic                      r_valid_q;
  logic                      r_is_read_q;
  logic [IW-1:0]             r_id_q;

  logic                      grant;
  logic                      ts_hit;
  logic [ADDR_MEM_WIDTH-1:0] req_idx;
  logic                      unused_addr_bits;

  assign req_idx = tcdm_add_i[ADDR_MEM_WIDTH+1:2];
  assign grant   = (state_q == IDLE) && tcdm_req_i;
  assign ts_hit  = grant && tcdm_wen_i && tcdm_add_i[TS_BIT];

  // Byte-offset and upper address bits are intentionally dropped.
  assign unused_addr_bits = ^tcdm_add_i;

  assign tcdm_gnt_o = grant;

  always_comb begin
    mem_req_o   = tcdm_req_i;
    mem_we_o    = ~tcdm_wen_i;
    mem_addr_o  = req_idx;
    mem_wdata_o = tcdm_data_i;
    mem_be_o    = tcdm_be_i;
    if (state_q == TS_SET) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = ts_idx_q;
      mem_wdata_o = HCI_TS_FILL[DATA_WIDTH-1:0];
      mem_be_o    = HCI_TS_FILL[BE_W-1:0];
    end
  end

  // Reads pass SRAM data straight through; write responses carry zero.
  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_id_o    = r_id_q;
  assign tcdm_r_data_o  = r_is_read_q ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ts_idx_q    <= '0;
      r_valid_q   <= 1'b0;
      r_is_read_q <= 1'b0;
      r_id_q      <= '0;
    end else begin
      r_valid_q   <= grant;
      r_is_read_q <= grant && tcdm_wen_i;
      if (grant) begin
        r_id_q <= tcdm_id_i;
      end
      case (state_q)
        IDLE: begin
          if (ts_hit) begin
            ts_idx_q <= req_idx;
            state_q  <= TS_SET;
          end
        end
        TS_SET:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
